dram_req_arbiter: RTL and testbench

DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

---
 rtl/dram_req_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter
//   Two-requester (UART, D-cache) arbiter in front of a single DRAM request
//   port. Each requester owns one request slot; a start pulse fills the slot
//   if it is free. A five-state FSM grants one slot at a time, emits a
//   one-cycle downstream start pulse, holds the granted request on m_* until
//   the downstream finish pulse, then pulses the owner's done and frees the slot.
//
//   Build option: DRAM_ARB_DC_PRIORITY_EN -- when defined, the D-cache wins
//   every tie; otherwise ties alternate (round-robin on the last served).
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   uart_* / dc_*                   requester start pulses, addr, wdata, mask,
//                                   done pulse and read-beat valid
//   rdat_data                       read data shared by both requesters
//   m_wstart_rq, m_rstart_rq        downstream start pulses
//   m_addr, m_wdata, m_mask         downstream request, held while in service
//   m_finish_wresp, m_finish_mrd    downstream completion pulses
//   m_rdat_data, m_rdat_valid       downstream read beats

// One request slot. While busy it ignores new start pulses; it clears only
// when the arbiter signals that its transaction has completed.
module dram_req_slot #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wstart,
  input  logic          rstart,
  input  logic [AW-1:0] addr,
  input  logic [127:0]  wdata,
  input  logic [15:0]   mask,
  input  logic          free,
  output logic          busy,
  output logic          is_wr,
  output logic [AW-1:0] q_addr,
  output logic [127:0]  q_wdata,
  output logic [15:0]   q_mask
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      is_wr   <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_mask  <= '0;
    end else if (busy) begin
      if (free) busy <= 1'b0;
    end else if (wstart || rstart) begin
      busy    <= 1'b1;
      is_wr   <= wstart;   // a coincident read is dropped
      q_addr  <= addr;
      q_wdata <= wdata;
      q_mask  <= mask;
    end
  end

endmodule

module dram_req_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_wstart_rq,
  input  logic          uart_rstart_rq,
  input  logic [AW-1:0] uart_addr,
  input  logic [127:0]  uart_wdata,
  input  logic [15:0]   uart_mask,
  output logic          uart_done,
  output logic          uart_rdat_valid,
  input  logic          dc_wstart_rq,
  input  logic          dc_rstart_rq,
  input  logic [AW-1:0] dc_addr,
  input  logic [127:0]  dc_wdata,
  input  logic [15:0]   dc_mask,
  output logic          dc_done,
  output logic          dc_rdat_valid,
  output logic [127:0]  rdat_data,
  output logic          m_wstart_rq,
  output logic          m_rstart_rq,
  output logic [AW-1:0] m_addr,
  output logic [127:0]  m_wdata,
  output logic [15:0]   m_mask,
  input  logic          m_finish_wresp,
  input  logic [127:0]  m_rdat_data,
  input  logic          m_rdat_valid,
  input  logic          m_finish_mrd
);

  localparam int NREQ = 2;
  localparam int UART = 0;
  localparam int DC   = 1;

  typedef enum logic [2:0] {IDLE, WISSUE, WWAIT, RISSUE, RWAIT} state_t;

  state_t state, state_nx;

  // requester inputs gathered into lane-indexed arrays
  logic [NREQ-1:0]           in_w, in_r;
  logic [NREQ-1:0][AW-1:0]   in_addr;
  logic [NREQ-1:0][127:0]    in_wdata;
  logic [NREQ-1:0][15:0]     in_mask;

  logic [NREQ-1:0]           s_busy, s_wr, s_free;
  logic [NREQ-1:0][AW-1:0]   s_addr;
  logic [NREQ-1:0][127:0]    s_wdata;
  logic [NREQ-1:0][15:0]     s_mask;

  logic                      owner;   // 0 = uart, 1 = dc
  logic                      pick;    // requester chosen this cycle
  logic                      grant;
  logic                      fin;
  logic [NREQ-1:0]           done_q;
  logic                      active;
  logic                      rd_wait;

  assign in_w     = {dc_wstart_rq, uart_wstart_rq};
  assign in_r     = {dc_rstart_rq, uart_rstart_rq};
  assign in_addr  = {dc_addr,      uart_addr};
  assign in_wdata = {dc_wdata,     uart_wdata};
  assign in_mask  = {dc_mask,      uart_mask};

  // Only the owner's slot is ever freed, and only on its completion.
  assign s_free = {fin & owner, fin & ~owner};

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    dram_req_slot #(.AW(AW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wstart  (in_w[g]),
      .rstart  (in_r[g]),
      .addr    (in_addr[g]),
      .wdata   (in_wdata[g]),
      .mask    (in_mask[g]),
      .free    (s_free[g]),
      .busy    (s_busy[g]),
      .is_wr   (s_wr[g]),
      .q_addr  (s_addr[g]),
      .q_wdata (s_wdata[g]),
      .q_mask  (s_mask[g])
    );
  end

  // Grant selection. In IDLE no slot is in service, so busy == pending.
`ifdef DRAM_ARB_DC_PRIORITY_EN
  assign pick = s_busy[DC];
`else
  logic last_dc;   // last served requester; reset to uart so dc wins first tie

  assign pick = (&s_busy) ? ~last_dc : s_busy[DC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_dc <= 1'b0;
    else if (grant) last_dc <= pick;
  end
`endif

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|s_busy) begin
          grant    = 1'b1;
          state_nx = s_wr[pick] ? WISSUE : RISSUE;
        end
      end
      WISSUE: state_nx = WWAIT;
      WWAIT: begin
        if (m_finish_wresp) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      RISSUE: state_nx = RWAIT;
      RWAIT: begin
        if (m_finish_mrd) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      done_q <= '0;
    end else begin
      state  <= state_nx;
      done_q <= s_free;
      if (grant) owner <= pick;
    end
  end

  // Downstream request is the owner's slot, visible only while in service;
  // the gating also makes the outputs drop the moment reset asserts.
  assign active      = (state != IDLE);
  assign rd_wait     = (state == RWAIT);
  assign m_wstart_rq = (state == WISSUE);
  assign m_rstart_rq = (state == RISSUE);
  assign m_addr      = active ? s_addr[owner]  : '0;
  assign m_wdata     = active ? s_wdata[owner] : '0;
  assign m_mask      = active ? s_mask[owner]  : '0;

  // Read beats pass straight through to the owner with no added latency.
  assign rdat_data       = rd_wait ? m_rdat_data : '0;
  assign uart_rdat_valid = rd_wait & ~owner & m_rdat_valid;
  assign dc_rdat_valid   = rd_wait &  owner & m_rdat_valid;

  assign uart_done = done_q[UART];
  assign dc_done   = done_q[DC];

endmodule

// File: tb/tb_dram_req_arbiter.sv
module tb_dram_req_arbiter;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          uart_wstart_rq, uart_rstart_rq, dc_wstart_rq, dc_rstart_rq;
  logic [AW-1:0] uart_addr, dc_addr;
  logic [127:0]  uart_wdata, dc_wdata;
  logic [15:0]   uart_mask, dc_mask;
  logic          uart_done, uart_rdat_valid, dc_done, dc_rdat_valid;
  logic [127:0]  rdat_data;
  logic          m_wstart_rq, m_rstart_rq;
  logic [AW-1:0] m_addr;
  logic [127:0]  m_wdata;
  logic [15:0]   m_mask;
  logic          m_finish_wresp, m_finish_mrd, m_rdat_valid;
  logic [127:0]  m_rdat_data;

  dram_req_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_wstart_rq(uart_wstart_rq), .uart_rstart_rq(uart_rstart_rq),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_mask(uart_mask),
    .uart_done(uart_done), .uart_rdat_valid(uart_rdat_valid),
    .dc_wstart_rq(dc_wstart_rq), .dc_rstart_rq(dc_rstart_rq),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_mask(dc_mask),
    .dc_done(dc_done), .dc_rdat_valid(dc_rdat_valid),
    .rdat_data(rdat_data),
    .m_wstart_rq(m_wstart_rq), .m_rstart_rq(m_rstart_rq),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_finish_wresp(m_finish_wresp), .m_rdat_data(m_rdat_data),
    .m_rdat_valid(m_rdat_valid), .m_finish_mrd(m_finish_mrd)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] A5 = {16{8'hA5}};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, ".ws"},  m_wstart_rq, 0);
    chk({p, ".rs"},  m_rstart_rq, 0);
    chk({p, ".addr"}, m_addr, 0);
    chk({p, ".wdata"}, m_wdata, 0);
    chk({p, ".mask"}, m_mask, 0);
    chk({p, ".udone"}, uart_done, 0);
    chk({p, ".ddone"}, dc_done, 0);
    chk({p, ".uvld"}, uart_rdat_valid, 0);
    chk({p, ".dvld"}, dc_rdat_valid, 0);
    chk({p, ".rdat"}, rdat_data, 0);
  endtask

  // Write data derived from the address so each captured request is unique.
  function automatic logic [127:0] wd(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'd1};
  endfunction

  task automatic idle_inputs();
    uart_wstart_rq = 0; uart_rstart_rq = 0; dc_wstart_rq = 0; dc_rstart_rq = 0;
    uart_addr = 0; dc_addr = 0; uart_wdata = 0; dc_wdata = 0; uart_mask = 0; dc_mask = 0;
    m_finish_wresp = 0; m_finish_mrd = 0; m_rdat_valid = 0; m_rdat_data = 0;
  endtask

  // ---------------- directed per-cycle vector table ----------------
  typedef struct {
    bit uw, ur, dw, dr;
    logic [31:0] ua, da;
    bit fw, fr, rv;
    bit ws, rs;
    logic [31:0] ea;
    bit ud, dd, uv, dv, rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit uw, bit ur, bit dw, bit dr, logic [31:0] ua, logic [31:0] da,
                              bit fw, bit fr, bit rv, bit ws, bit rs, logic [31:0] ea,
                              bit ud, bit dd, bit uv, bit dv, bit rd);
    vec_t v;
    v.uw = uw; v.ur = ur; v.dw = dw; v.dr = dr; v.ua = ua; v.da = da;
    v.fw = fw; v.fr = fr; v.rv = rv; v.ws = ws; v.rs = rs; v.ea = ea;
    v.ud = ud; v.dd = dd; v.uv = uv; v.dv = dv; v.rd = rd;
    return v;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          p_pend[2];
  bit          p_wr[2];
  logic [31:0] p_a[2];
  logic [127:0] p_d[2];
  logic [15:0] p_k[2];
  int          p_cap[2];
  bit          r_infl;
  int          r_own;
  int          r_iss;
  int          r_free;
  bit          r_last_dc;

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin p_pend[r] = 0; p_cap[r] = 0; end
    r_infl = 0; r_own = 0; r_iss = -10; r_free = cyc; r_last_dc = 0;
  endtask

  // Apply the rules to the edge that just happened, then compare outputs.
  task automatic model_step(input int k);
    bit fin, iss, c0, c1, rw;
    bit dn[2];
    bit ws_i[2], rs_i[2];
    logic [31:0] a_i[2];
    logic [127:0] d_i[2];
    logic [15:0] k_i[2];
    logic [31:0] e_a;
    logic [127:0] e_d;
    logic [15:0] e_k;
    string p;
    ws_i[0] = uart_wstart_rq; rs_i[0] = uart_rstart_rq; a_i[0] = uart_addr; d_i[0] = uart_wdata; k_i[0] = uart_mask;
    ws_i[1] = dc_wstart_rq;   rs_i[1] = dc_rstart_rq;   a_i[1] = dc_addr;   d_i[1] = dc_wdata;   k_i[1] = dc_mask;
    // completion only counts once the request sits in its wait phase
    fin = r_infl && (r_iss <= cyc - 2) && (p_wr[r_own] ? m_finish_wresp : m_finish_mrd);
    for (int r = 0; r < 2; r++) begin
      dn[r] = 0;
      if (!p_pend[r] && (ws_i[r] || rs_i[r])) begin
        p_pend[r] = 1; p_wr[r] = ws_i[r]; p_a[r] = a_i[r]; p_d[r] = d_i[r]; p_k[r] = k_i[r];
        p_cap[r] = cyc;
      end
    end
    if (fin) begin dn[r_own] = 1; p_pend[r_own] = 0; r_infl = 0; r_free = cyc; end
    iss = 0;
    if (!r_infl && r_free < cyc) begin
      c0 = p_pend[0] && p_cap[0] < cyc;
      c1 = p_pend[1] && p_cap[1] < cyc;
      if (c0 || c1) begin
        if (c0 && c1) begin
`ifdef DRAM_ARB_DC_PRIORITY_EN
          r_own = 1;
`else
          r_own = r_last_dc ? 0 : 1;
`endif
        end else r_own = c1 ? 1 : 0;
        r_last_dc = (r_own == 1);
        r_infl = 1; iss = 1; r_iss = cyc;
      end
    end
    rw  = r_infl && !p_wr[r_own] && r_iss < cyc;
    e_a = r_infl ? p_a[r_own] : 0;
    e_d = r_infl ? p_d[r_own] : 0;
    e_k = r_infl ? p_k[r_own] : 0;
    p = $sformatf("rnd%0d", k);
    chk({p, ".ws"},    m_wstart_rq, iss && p_wr[r_own]);
    chk({p, ".rs"},    m_rstart_rq, iss && !p_wr[r_own]);
    chk({p, ".addr"},  m_addr, e_a);
    chk({p, ".wdata"}, m_wdata, e_d);
    chk({p, ".mask"},  m_mask, e_k);
    chk({p, ".udone"}, uart_done, dn[0]);
    chk({p, ".ddone"}, dc_done, dn[1]);
    chk({p, ".uvld"},  uart_rdat_valid, rw && r_own == 0 && m_rdat_valid);
    chk({p, ".dvld"},  dc_rdat_valid, rw && r_own == 1 && m_rdat_valid);
    chk({p, ".rdat"},  rdat_data, rw ? m_rdat_data : 128'd0);
  endtask

  initial begin
    idle_inputs();

    // ---- reset state, with start pulses that must be ignored ----
    @(negedge clk);
    uart_wstart_rq = 1; dc_rstart_rq = 1; uart_addr = 32'h44;
    m_finish_wresp = 1; m_rdat_valid = 1; m_rdat_data = A5;
    @(negedge clk);
    chk_zero("reset");
    idle_inputs();
    rst_n = 1;

    // ---- table: tie after reset, read pass-through, write, stray finish, w+r ----
    tbl.push_back(mk(0,1,0,1, 32'h200,32'h300, 0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,1, 0,1,32'h300, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,1, 0,0,32'h300, 0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,1,0, 0,0,32'h000, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,1, 0,1,32'h200, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,1, 0,0,32'h200, 0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,1,0, 0,0,32'h000, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 32'h100,0,       0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 1,0,32'h100, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h100, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             1,0,0, 0,0,32'h000, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             1,1,1, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 32'h400,0,       0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 1,0,32'h400, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,1,1, 0,0,32'h400, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             1,0,0, 0,0,32'h000, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,             0,0,0, 0,0,32'h000, 0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      string p;
      v = tbl[i];
      uart_wstart_rq = v.uw; uart_rstart_rq = v.ur; uart_addr = v.ua;
      uart_wdata = wd(v.ua); uart_mask = 16'hFFFF;
      dc_wstart_rq = v.dw; dc_rstart_rq = v.dr; dc_addr = v.da;
      dc_wdata = wd(v.da); dc_mask = 16'hFFFF;
      m_finish_wresp = v.fw; m_finish_mrd = v.fr; m_rdat_valid = v.rv; m_rdat_data = A5;
      @(negedge clk);
      p = $sformatf("t%0d", i);
      chk({p, ".ws"},    m_wstart_rq, v.ws);
      chk({p, ".rs"},    m_rstart_rq, v.rs);
      chk({p, ".addr"},  m_addr, v.ea);
      chk({p, ".wdata"}, m_wdata, (v.ea != 0) ? wd(v.ea) : 128'd0);
      chk({p, ".mask"},  m_mask, (v.ea != 0) ? 16'hFFFF : 16'h0);
      chk({p, ".udone"}, uart_done, v.ud);
      chk({p, ".ddone"}, dc_done, v.dd);
      chk({p, ".uvld"},  uart_rdat_valid, v.uv);
      chk({p, ".dvld"},  dc_rdat_valid, v.dv);
      chk({p, ".rdat"},  rdat_data, v.rd ? A5 : 128'd0);
    end

    // ---- reset dropped in the middle of a write wait ----
    idle_inputs();
    uart_wstart_rq = 1; uart_addr = 32'h500; uart_wdata = wd(32'h500); uart_mask = 16'h0F0F;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("mr.issue", m_wstart_rq, 1);
    @(negedge clk);
    chk("mr.wait_addr", m_addr, 32'h500);
    chk("mr.wait_mask", m_mask, 16'h0F0F);
    #2 rst_n = 0;
    #1 chk_zero("mr.async");
    @(negedge clk);
    chk_zero("mr.held");
    rst_n = 1;
    @(negedge clk);
    m_finish_wresp = 1;
    @(negedge clk);
    m_finish_wresp = 0;
    chk_zero("mr.stray");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_zero($sformatf("mr.after%0d", i));
    end

    // ---- randomized traffic against the model ----
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int k = 0; k < 4000; k++) begin
      uart_wstart_rq = ($urandom_range(0, 3) == 0);
      uart_rstart_rq = ($urandom_range(0, 3) == 0);
      uart_addr      = $urandom;
      uart_wdata     = {$urandom, $urandom, $urandom, $urandom};
      uart_mask      = 16'($urandom);
      dc_wstart_rq   = ($urandom_range(0, 3) == 0);
      dc_rstart_rq   = ($urandom_range(0, 3) == 0);
      dc_addr        = $urandom;
      dc_wdata       = {$urandom, $urandom, $urandom, $urandom};
      dc_mask        = 16'($urandom);
      m_finish_wresp = ($urandom_range(0, 4) == 0);
      m_finish_mrd   = ($urandom_range(0, 4) == 0);
      m_rdat_valid   = ($urandom_range(0, 1) == 1);
      m_rdat_data    = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      model_step(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
